rf_wb_buffer: RTL and testbench

- Write-side buffer in front of the register file's single write port. Multi-cycle execution units (mul/div, load return) push (rd, result) pairs through a valid/ready handshake.
- Pairs drain in FIFO order onto the register-file write port when the pipeline grants the port.
- Provides combinational pending/forwarding lookups for two source registers, so issue logic can stall on or bypass buffered results.
- Writes to x0 are discarded at entry.

---
 rtl/rf_wb_buffer_if.sv | 37 +++
 rtl/rf_wb_buffer.sv | 112 +++++++++++
 tb/tb_rf_wb_buffer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_buffer_if.sv
// Bus bundle for the register-file write buffer: producer handshake,
// write-port grant and registered write port, source lookups and occupancy.
interface rf_wb_buffer_if #(
    parameter int DEPTH         = 4,
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [RF_ADDR_WIDTH-1:0]   in_addr;
    logic [XLEN-1:0]            in_data;
    logic                       drain_en;
    logic                       rf_wr_en;
    logic [RF_ADDR_WIDTH-1:0]   rf_wr_addr;
    logic [XLEN-1:0]            rf_wr_data;
    logic [RF_ADDR_WIDTH-1:0]   lu_addr_a;
    logic [RF_ADDR_WIDTH-1:0]   lu_addr_b;
    logic                       lu_hit_a;
    logic                       lu_hit_b;
    logic [XLEN-1:0]            lu_data_a;
    logic [XLEN-1:0]            lu_data_b;
    logic [$clog2(DEPTH):0]     count;

    // Producer / pipeline side
    modport master (
        output in_valid, in_addr, in_data, drain_en, lu_addr_a, lu_addr_b,
        input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
               lu_hit_a, lu_hit_b, lu_data_a, lu_data_b, count
    );

    // Buffer side
    modport slave (
        input  in_valid, in_addr, in_data, drain_en, lu_addr_a, lu_addr_b,
        output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data,
               lu_hit_a, lu_hit_b, lu_data_a, lu_data_b, count
    );
endinterface

// File: rtl/rf_wb_buffer.sv
// Write-side FIFO in front of the register file write port. Results from
// multi-cycle units queue here, drain in order when the port is granted,
// and are visible to issue logic through two combinational lookups.
module rf_wb_buffer #(
    parameter int DEPTH         = 4,
    parameter int XLEN          = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input logic          clk,
    input logic          rst_n,
    rf_wb_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [XLEN-1:0]          word_t;
    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

    rf_addr_t        mem_addr [DEPTH];
    word_t           mem_data [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            wr_en_q;
    rf_addr_t        wr_addr_q;
    word_t           wr_data_q;
    logic            full;
    logic            push;
    logic            pop;

    // Full is judged on the current count only; a same-cycle pop never opens space.
    assign full         = (count_q == CW'(DEPTH));
    assign bus.in_ready = rst_n && !full;
    // x0 results complete the handshake but are never stored.
    assign push         = bus.in_valid && bus.in_ready && (bus.in_addr != '0);
    assign pop          = bus.drain_en && (count_q != '0);

    assign bus.count      = count_q;
    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_wr_addr = wr_addr_q;
    assign bus.rf_wr_data = wr_data_q;

    // Entry storage; contents only matter while covered by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= bus.in_addr;
            mem_data[wr_ptr] <= bus.in_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered write port: head moves here on a grant, address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= pop;
            if (pop) begin
                wr_addr_q <= mem_addr[rd_ptr];
                wr_data_q <= mem_data[rd_ptr];
            end
        end
    end

    // Output register is the oldest candidate; FIFO entries are scanned
    // oldest to newest so the youngest match overrides.
    function automatic logic [XLEN:0] lookup(input rf_addr_t a);
        logic          hit;
        word_t         d;
        logic [PW-1:0] idx;
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            if (wr_en_q && (wr_addr_q == a)) begin
                hit = 1'b1;
                d   = wr_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PW'(k);
                if ((CW'(k) < count_q) && (mem_addr[idx] == a)) begin
                    hit = 1'b1;
                    d   = mem_data[idx];
                end
            end
        end
        return {hit, d};
    endfunction

    // Two independent source lookups for issue stall/bypass.
    always_comb begin
        {bus.lu_hit_a, bus.lu_data_a} = lookup(bus.lu_addr_a);
        {bus.lu_hit_b, bus.lu_data_b} = lookup(bus.lu_addr_b);
    end
endmodule

// File: tb/tb_rf_wb_buffer.sv
// Directed bench for rf_wb_buffer: a table of per-cycle vectors plus
// hand-written sequences for wrap-around and mid-operation reset.
module tb_rf_wb_buffer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    rf_wb_buffer_if #(.DEPTH(4), .XLEN(32), .RF_ADDR_WIDTH(5)) bus ();

    rf_wb_buffer #(.DEPTH(4), .XLEN(32), .RF_ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        dr;
        logic [4:0]  la;
        logic [4:0]  lb;
        logic        rdy;
        logic [2:0]  cnt;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ha;
        logic [31:0] da;
        logic        hb;
        logic [31:0] db;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [31:0] d,
                                input logic dr, input logic [4:0] la, input logic [4:0] lb,
                                input logic rdy, input logic [2:0] cnt, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic ha, input logic [31:0] da,
                                input logic hb, input logic [31:0] db);
        vec_t r;
        r.v = v; r.a = a; r.d = d; r.dr = dr; r.la = la; r.lb = lb;
        r.rdy = rdy; r.cnt = cnt; r.we = we; r.wa = wa; r.wd = wd;
        r.ha = ha; r.da = da; r.hb = hb; r.db = db;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic dr, input logic [4:0] la, input logic [4:0] lb);
        bus.in_valid  = v;
        bus.in_addr   = a;
        bus.in_data   = d;
        bus.drain_en  = dr;
        bus.lu_addr_a = la;
        bus.lu_addr_b = lb;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        //          v  a   d             dr la lb  rdy cnt we wa  wd            ha da            hb db
        tbl[0]  = mk(1, 5, 32'hdead_beef, 1, 5, 0,  1, 1, 0, 0, 32'h0,         1, 32'hdead_beef, 0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,         1, 5, 0,  1, 0, 1, 5, 32'hdead_beef, 1, 32'hdead_beef, 0, 32'h0);
        tbl[2]  = mk(1, 0, 32'hffff_ffff, 1, 0, 5,  1, 0, 0, 5, 32'hdead_beef, 0, 32'h0,         0, 32'h0);
        tbl[3]  = mk(0, 0, 32'h0,         1, 0, 0,  1, 0, 0, 5, 32'hdead_beef, 0, 32'h0,         0, 32'h0);
        tbl[4]  = mk(1, 1, 32'h101,       0, 1, 2,  1, 1, 0, 5, 32'hdead_beef, 1, 32'h101,       0, 32'h0);
        tbl[5]  = mk(1, 2, 32'h202,       0, 1, 2,  1, 2, 0, 5, 32'hdead_beef, 1, 32'h101,       1, 32'h202);
        tbl[6]  = mk(1, 3, 32'h303,       0, 1, 3,  1, 3, 0, 5, 32'hdead_beef, 1, 32'h101,       1, 32'h303);
        tbl[7]  = mk(1, 4, 32'h404,       0, 4, 3,  0, 4, 0, 5, 32'hdead_beef, 1, 32'h404,       1, 32'h303);
        tbl[8]  = mk(1, 5, 32'h505,       0, 5, 1,  0, 4, 0, 5, 32'hdead_beef, 0, 32'h0,         1, 32'h101);
        tbl[9]  = mk(1, 5, 32'h505,       1, 1, 5,  1, 3, 1, 1, 32'h101,       1, 32'h101,       0, 32'h0);
        tbl[10] = mk(0, 0, 32'h0,         1, 2, 4,  1, 2, 1, 2, 32'h202,       1, 32'h202,       1, 32'h404);
        tbl[11] = mk(0, 0, 32'h0,         1, 3, 0,  1, 1, 1, 3, 32'h303,       1, 32'h303,       0, 32'h0);
        tbl[12] = mk(0, 0, 32'h0,         1, 4, 0,  1, 0, 1, 4, 32'h404,       1, 32'h404,       0, 32'h0);
        tbl[13] = mk(0, 0, 32'h0,         1, 4, 0,  1, 0, 0, 4, 32'h404,       0, 32'h0,         0, 32'h0);
        tbl[14] = mk(1, 7, 32'h1111_1111, 0, 7, 0,  1, 1, 0, 4, 32'h404,       1, 32'h1111_1111, 0, 32'h0);
        tbl[15] = mk(1, 7, 32'h2222_2222, 0, 7, 0,  1, 2, 0, 4, 32'h404,       1, 32'h2222_2222, 0, 32'h0);
        tbl[16] = mk(0, 0, 32'h0,         1, 7, 7,  1, 1, 1, 7, 32'h1111_1111, 1, 32'h2222_2222, 1, 32'h2222_2222);
        tbl[17] = mk(0, 0, 32'h0,         1, 7, 0,  1, 0, 1, 7, 32'h2222_2222, 1, 32'h2222_2222, 0, 32'h0);
        tbl[18] = mk(0, 0, 32'h0,         1, 7, 0,  1, 0, 0, 7, 32'h2222_2222, 0, 32'h0,         0, 32'h0);
        tbl[19] = mk(1, 9, 32'h5555_5555, 0, 0, 9,  1, 1, 0, 7, 32'h2222_2222, 0, 32'h0,         1, 32'h5555_5555);
        tbl[20] = mk(0, 0, 32'h0,         1, 0, 9,  1, 0, 1, 9, 32'h5555_5555, 0, 32'h0,         1, 32'h5555_5555);
        tbl[21] = mk(0, 0, 32'h0,         1, 0, 9,  1, 0, 0, 9, 32'h5555_5555, 0, 32'h0,         0, 32'h0);

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst.count", 32'(bus.count), 32'd0);
        chk("rst.wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("rst.wr_addr", 32'(bus.rf_wr_addr), 32'd0);
        chk("rst.wr_data", bus.rf_wr_data, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready", 32'(bus.in_ready), 32'd1);

        // Table vectors: inputs held for one cycle, outputs checked after the edge
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].dr, tbl[i].la, tbl[i].lb);
            cycle();
            chk($sformatf("row%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d.count", i), 32'(bus.count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d.wr_en", i), 32'(bus.rf_wr_en), 32'(tbl[i].we));
            chk($sformatf("row%0d.wr_addr", i), 32'(bus.rf_wr_addr), 32'(tbl[i].wa));
            chk($sformatf("row%0d.wr_data", i), bus.rf_wr_data, tbl[i].wd);
            chk($sformatf("row%0d.hit_a", i), 32'(bus.lu_hit_a), 32'(tbl[i].ha));
            chk($sformatf("row%0d.data_a", i), bus.lu_data_a, tbl[i].da);
            chk($sformatf("row%0d.hit_b", i), 32'(bus.lu_hit_b), 32'(tbl[i].hb));
            chk($sformatf("row%0d.data_b", i), bus.lu_data_b, tbl[i].db);
        end

        // Continuous push+pop for 3*DEPTH entries: pointers wrap three times
        for (int c = 0; c < 14; c++) begin
            if (c < 12)
                drive(1, 5'(c + 1), 32'hA000_0000 + 32'(c), 1, 0, 0);
            else
                drive(0, 0, 0, 1, 0, 0);
            cycle();
            chk($sformatf("wrap%0d.count", c), 32'(bus.count), (c < 12) ? 32'd1 : 32'd0);
            chk($sformatf("wrap%0d.wr_en", c), 32'(bus.rf_wr_en), (c >= 1 && c <= 12) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 12) begin
                chk($sformatf("wrap%0d.wr_addr", c), 32'(bus.rf_wr_addr), 32'(c));
                chk($sformatf("wrap%0d.wr_data", c), bus.rf_wr_data, 32'hA000_0000 + 32'(c - 1));
            end
        end

        // Mid-operation reset with three entries queued
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'(10 + c), 32'hC000_0000 + 32'(c), 0, 10, 0);
            cycle();
        end
        drive(0, 0, 0, 1, 10, 0);
        #1;
        chk("mid.count", 32'(bus.count), 32'd3);
        chk("mid.hit_a", 32'(bus.lu_hit_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst.count", 32'(bus.count), 32'd0);
        chk("mrst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst.wr_en", 32'(bus.rf_wr_en), 32'd0);
        chk("mrst.wr_addr", 32'(bus.rf_wr_addr), 32'd0);
        chk("mrst.wr_data", bus.rf_wr_data, 32'd0);
        chk("mrst.hit_a", 32'(bus.lu_hit_a), 32'd0);
        chk("mrst.data_a", bus.lu_data_a, 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk($sformatf("post%0d.wr_en", c), 32'(bus.rf_wr_en), 32'd0);
            chk($sformatf("post%0d.count", c), 32'(bus.count), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
